// File: rtl/ysyx_25040129_pkg.sv
// Shared definitions for the AXI4-Lite memory-port arbiter: FSM state
// encoding, response codes and write-strobe encodings.
package ysyx_25040129_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_M0_AR = 3'd1,
        ST_M0_R  = 3'd2,
        ST_M1_AR = 3'd3,
        ST_M1_R  = 3'd4,
        ST_M1_WR = 3'd5,
        ST_M1_B  = 3'd6
    } arb_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] WSTRB_BYTE = 2'b01;
    localparam logic [1:0] WSTRB_HALF = 2'b10;
    localparam logic [1:0] WSTRB_WORD = 2'b11;

endpackage

// File: rtl/ysyx_25040129_axil_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter.
// One transaction at a time, LSU has priority, handshakes forwarded combinationally.
module ysyx_25040129_axil_arbiter
    import ysyx_25040129_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_araddr,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rvalid,
    input  logic        m0_rready,

    input  logic [31:0] m1_araddr,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    input  logic [31:0] m1_awaddr,
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [31:0] m1_wdata,
    input  logic [1:0]  m1_wstrb,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    output logic [1:0]  m1_bresp,
    output logic        m1_bvalid,
    input  logic        m1_bready,

    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready,
    output logic [31:0] s_awaddr,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_wdata,
    output logic [1:0]  s_wstrb,
    output logic        s_wvalid,
    input  logic        s_wready,
    input  logic [1:0]  s_bresp,
    input  logic        s_bvalid,
    output logic        s_bready
);

    arb_state_e state_q, state_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic       aw_fire_s, w_fire_s;

    // Handshake detection on the slave side of the write channels
    always_comb begin
        aw_fire_s = s_awvalid & s_awready;
        w_fire_s  = s_wvalid & s_wready;
    end

    // Next-state selection; IDLE grant order is m1 read, m1 write, m0 read
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m1_arvalid) begin
                    state_d = ST_M1_AR;
                end else if (m1_awvalid || m1_wvalid) begin
                    state_d = ST_M1_WR;
                end else if (m0_arvalid) begin
                    state_d = ST_M0_AR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_M0_AR: begin
                if (m0_arvalid && s_arready) state_d = ST_M0_R;
                else                         state_d = ST_M0_AR;
            end
            ST_M0_R: begin
                if (s_rvalid && m0_rready) state_d = ST_IDLE;
                else                       state_d = ST_M0_R;
            end
            ST_M1_AR: begin
                if (m1_arvalid && s_arready) state_d = ST_M1_R;
                else                         state_d = ST_M1_AR;
            end
            ST_M1_R: begin
                if (s_rvalid && m1_rready) state_d = ST_IDLE;
                else                       state_d = ST_M1_R;
            end
            ST_M1_WR: begin
                if ((aw_done_q || aw_fire_s) && (w_done_q || w_fire_s)) state_d = ST_M1_B;
                else                                                    state_d = ST_M1_WR;
            end
            ST_M1_B: begin
                if (s_bvalid && m1_bready) state_d = ST_IDLE;
                else                       state_d = ST_M1_B;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write-channel completion flags: set on handshake, cleared whenever heading to IDLE
    always_comb begin
        if (state_d == ST_IDLE) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else if (state_q == ST_M1_WR) begin
            aw_done_d = aw_done_q | aw_fire_s;
            w_done_d  = w_done_q | w_fire_s;
        end else begin
            aw_done_d = aw_done_q;
            w_done_d  = w_done_q;
        end
    end

    // State and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Channel routing: everything idles at zero unless the current state owns it
    always_comb begin
        m0_arready = 1'b0;
        m0_rdata   = 32'h0000_0000;
        m0_rresp   = 2'b00;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = 32'h0000_0000;
        m1_rresp   = 2'b00;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bresp   = 2'b00;
        m1_bvalid  = 1'b0;
        s_araddr   = 32'h0000_0000;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awaddr   = 32'h0000_0000;
        s_awvalid  = 1'b0;
        s_wdata    = 32'h0000_0000;
        s_wstrb    = 2'b00;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_arvalid = 1'b0;
            end
            ST_M0_AR: begin
                s_araddr   = m0_araddr;
                s_arvalid  = m0_arvalid;
                m0_arready = s_arready;
            end
            ST_M0_R: begin
                m0_rdata  = s_rdata;
                m0_rresp  = s_rresp;
                m0_rvalid = s_rvalid;
                s_rready  = m0_rready;
            end
            ST_M1_AR: begin
                s_araddr   = m1_araddr;
                s_arvalid  = m1_arvalid;
                m1_arready = s_arready;
            end
            ST_M1_R: begin
                m1_rdata  = s_rdata;
                m1_rresp  = s_rresp;
                m1_rvalid = s_rvalid;
                s_rready  = m1_rready;
            end
            ST_M1_WR: begin
                // A channel that has already handshaken is masked so it cannot fire twice
                s_awaddr   = m1_awaddr;
                s_awvalid  = m1_awvalid & ~aw_done_q;
                m1_awready = s_awready & ~aw_done_q;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wvalid   = m1_wvalid & ~w_done_q;
                m1_wready  = s_wready & ~w_done_q;
            end
            ST_M1_B: begin
                m1_bresp  = s_bresp;
                m1_bvalid = s_bvalid;
                s_bready  = m1_bready;
            end
            default: begin
                s_arvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_25040129_axil_arbiter.sv
// Directed bench for the AXI4-Lite arbiter: a grant-priority vector table
// followed by hand-written multi-cycle read/write/reset sequences.
module tb_ysyx_25040129_axil_arbiter;
    import ysyx_25040129_pkg::*;

    logic        clk, rst;
    logic [31:0] m0_araddr;  logic m0_arvalid; logic m0_arready;
    logic [31:0] m0_rdata;   logic [1:0] m0_rresp; logic m0_rvalid; logic m0_rready;
    logic [31:0] m1_araddr;  logic m1_arvalid; logic m1_arready;
    logic [31:0] m1_rdata;   logic [1:0] m1_rresp; logic m1_rvalid; logic m1_rready;
    logic [31:0] m1_awaddr;  logic m1_awvalid; logic m1_awready;
    logic [31:0] m1_wdata;   logic [1:0] m1_wstrb; logic m1_wvalid; logic m1_wready;
    logic [1:0]  m1_bresp;   logic m1_bvalid; logic m1_bready;
    logic [31:0] s_araddr;   logic s_arvalid; logic s_arready;
    logic [31:0] s_rdata;    logic [1:0] s_rresp; logic s_rvalid; logic s_rready;
    logic [31:0] s_awaddr;   logic s_awvalid; logic s_awready;
    logic [31:0] s_wdata;    logic [1:0] s_wstrb; logic s_wvalid; logic s_wready;
    logic [1:0]  s_bresp;    logic s_bvalid; logic s_bready;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] A0 = 32'h8000_0000;
    localparam logic [31:0] A1 = 32'h8000_1000;
    localparam logic [31:0] AW = 32'h8000_2000;

    ysyx_25040129_axil_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m0_ar;
        logic        m1_ar;
        logic        m1_aw;
        logic        m1_w;
        logic [6:0]  exp_ctl;    // {s_arvalid,s_awvalid,s_wvalid,m0_arready,m1_arready,m1_awready,m1_wready}
        logic [31:0] exp_araddr;
        logic [31:0] exp_awaddr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] all_ctl();
        return {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready,
                m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
    endfunction

    function automatic logic [31:0] all_data_or();
        return m0_rdata | m1_rdata | s_araddr | s_awaddr | s_wdata |
               {24'h0, m0_rresp, m1_rresp, m1_bresp, s_wstrb};
    endfunction

    task automatic clear_inputs();
        m0_araddr = 32'h0; m0_arvalid = 1'b0; m0_rready = 1'b0;
        m1_araddr = 32'h0; m1_arvalid = 1'b0; m1_rready = 1'b0;
        m1_awaddr = 32'h0; m1_awvalid = 1'b0; m1_wdata = 32'h0; m1_wstrb = 2'b00;
        m1_wvalid = 1'b0;  m1_bready = 1'b0;
        s_arready = 1'b0;  s_rdata = 32'h0; s_rresp = 2'b00; s_rvalid = 1'b0;
        s_awready = 1'b0;  s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    // Slave side of one read; the requesting master's arvalid must already be up
    task automatic slave_read(input int who, input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] resp, input int delay);
        int n;
        n = 0;
        s_arready = 1'b1;
        #1;
        while (s_arvalid !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk("ar_wait_budget", (n < 20) ? 32'd1 : 32'd0, 32'd1);
        chk("s_araddr", s_araddr, addr);
        chk("granted_arready", (who == 0) ? m0_arready : m1_arready, 32'd1);
        chk("other_arready", (who == 0) ? m1_arready : m0_arready, 32'd0);
        chk("no_write_during_ar", {s_awvalid, s_wvalid, m1_awready, m1_wready}, 32'd0);
        tick();
        if (who == 0) begin m0_arvalid = 1'b0; m0_rready = 1'b1; end
        else          begin m1_arvalid = 1'b0; m1_rready = 1'b1; end
        s_arready = 1'b0;
        for (int i = 0; i < delay; i++) begin
            #1;
            chk("rvalid_before_data", (who == 0) ? m0_rvalid : m1_rvalid, 32'd0);
            tick();
        end
        s_rvalid = 1'b1; s_rdata = data; s_rresp = resp;
        #1;
        chk("rvalid", (who == 0) ? m0_rvalid : m1_rvalid, 32'd1);
        chk("rdata", (who == 0) ? m0_rdata : m1_rdata, data);
        chk("rresp", (who == 0) ? m0_rresp : m1_rresp, resp);
        chk("s_rready", s_rready, 32'd1);
        chk("other_resp_idle", {(who == 0) ? m1_rvalid : m0_rvalid, m1_bvalid, m0_arready}, 32'd0);
        chk("no_overlap_in_r", {s_arvalid, s_awvalid, s_wvalid}, 32'd0);
        tick();
        s_rvalid = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00;
        m0_rready = 1'b0; m1_rready = 1'b0;
        #1;
        chk("idle_after_read", {m0_rvalid, m1_rvalid, s_rready, m0_arready}, 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000, 32'h0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 7'b1001000, A0,    32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 7'b1000100, A1,    32'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 7'b0100011, 32'h0, AW};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 7'b0010011, 32'h0, AW};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 7'b1000100, A1,    32'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 7'b0100011, 32'h0, AW};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 7'b1000100, A1,    32'h0};

        clear_inputs();
        rst = 1'b0;
        // Busy slave and requesting masters while reset is held: nothing may leak through
        s_rdata = 32'hFFFF_FFFF; s_rresp = RESP_SLVERR; s_rvalid = 1'b1; s_bvalid = 1'b1;
        s_bresp = RESP_SLVERR; s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; m1_awvalid = 1'b1; m1_wvalid = 1'b1;
        m0_rready = 1'b1; m1_rready = 1'b1; m1_bready = 1'b1;
        m0_araddr = A0; m1_araddr = A1; m1_awaddr = AW; m1_wdata = 32'h5555_AAAA;
        m1_wstrb = WSTRB_WORD;
        #3;
        chk("reset_ctl", all_ctl(), 32'd0);
        chk("reset_data", all_data_or(), 32'd0);
        tick(); tick();
        chk("reset_ctl_clocked", all_ctl(), 32'd0);
        clear_inputs();
        rst = 1'b1;
        tick();

        // Grant-priority table: request set in IDLE, inspect the granted state
        for (int v = 0; v < 8; v++) begin
            pulse_reset();
            clear_inputs();
            s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
            m0_araddr = A0; m1_araddr = A1; m1_awaddr = AW;
            m0_arvalid = vecs[v].m0_ar; m1_arvalid = vecs[v].m1_ar;
            m1_awvalid = vecs[v].m1_aw; m1_wvalid = vecs[v].m1_w;
            #1;
            chk($sformatf("v%0d_idle_ctl", v), all_ctl(), 32'd0);
            chk($sformatf("v%0d_idle_addr", v), s_araddr | s_awaddr, 32'd0);
            tick();
            #1;
            chk($sformatf("v%0d_grant_ctl", v),
                {s_arvalid, s_awvalid, s_wvalid, m0_arready, m1_arready, m1_awready, m1_wready},
                {25'd0, vecs[v].exp_ctl});
            chk($sformatf("v%0d_araddr", v), s_araddr, vecs[v].exp_araddr);
            chk($sformatf("v%0d_awaddr", v), s_awaddr, vecs[v].exp_awaddr);
        end
        pulse_reset();
        clear_inputs();
        tick();

        // IFU read with a 5-cycle slave delay
        m0_araddr = A0; m0_arvalid = 1'b1;
        slave_read(0, A0, 32'h0000_0413, RESP_OKAY, 5);

        // Simultaneous requests: LSU first, IFU afterwards
        m0_araddr = A0; m0_arvalid = 1'b1;
        m1_araddr = A1; m1_arvalid = 1'b1;
        slave_read(1, A1, 32'hDEAD_BEEF, RESP_OKAY, 1);
        chk("m0_pending_arready", m0_arready, 32'd0);
        slave_read(0, A0, 32'h1234_0001, RESP_OKAY, 2);

        // LSU write, W arrives two cycles after AW
        tick();
        m1_awaddr = AW; m1_awvalid = 1'b1; m1_bready = 1'b1;
        s_awready = 1'b1; s_wready = 1'b1;
        #1;
        chk("wr_idle_awvalid", s_awvalid, 32'd0);
        tick(); #1;
        chk("wr_aw_fwd", {s_awvalid, m1_awready, s_wvalid}, 32'b110);
        chk("wr_awaddr", s_awaddr, AW);
        tick();
        m1_awvalid = 1'b0;
        #1;
        chk("wr_aw_blocked", {s_awvalid, m1_awready, m1_bvalid}, 32'd0);
        tick();
        m1_wvalid = 1'b1; m1_wdata = 32'h1234_5678; m1_wstrb = WSTRB_WORD;
        #1;
        chk("wr_w_fwd", {s_wvalid, m1_wready, m1_bvalid, s_bready}, 32'b1100);
        chk("wr_wdata", s_wdata, 32'h1234_5678);
        chk("wr_wstrb", s_wstrb, WSTRB_WORD);
        tick();
        m1_wvalid = 1'b0;
        #1;
        chk("wr_b_wait", {m1_bvalid, s_bready, s_wvalid, m1_wready}, 32'b0100);
        s_bvalid = 1'b1; s_bresp = RESP_OKAY;
        #1;
        chk("wr_bvalid", m1_bvalid, 32'd1);
        chk("wr_bresp", m1_bresp, RESP_OKAY);
        tick();
        s_bvalid = 1'b0; m1_bready = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        #1;
        chk("wr_done_idle", {m1_bvalid, s_bready}, 32'd0);

        // Read and write requested together: read first, then write with AW/W in one cycle
        m1_araddr = 32'h8000_3000; m1_arvalid = 1'b1;
        m1_awaddr = 32'h8000_4000; m1_awvalid = 1'b1;
        m1_wdata = 32'hCAFE_F00D; m1_wstrb = WSTRB_HALF; m1_wvalid = 1'b1;
        s_awready = 1'b1; s_wready = 1'b1; m1_bready = 1'b1;
        slave_read(1, 32'h8000_3000, 32'h0BAD_0BAD, RESP_SLVERR, 0);
        n = 0;
        while (s_awvalid !== 1'b1 && n < 5) begin tick(); #1; n++; end
        chk("rw_aw_budget", (n < 5) ? 32'd1 : 32'd0, 32'd1);
        chk("rw_fwd", {s_awvalid, s_wvalid, s_arvalid}, 32'b110);
        chk("rw_awaddr", s_awaddr, 32'h8000_4000);
        chk("rw_wdata", s_wdata, 32'hCAFE_F00D);
        chk("rw_wstrb", s_wstrb, WSTRB_HALF);
        tick();
        m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        s_bvalid = 1'b1; s_bresp = RESP_SLVERR;
        #1;
        chk("rw_bvalid", m1_bvalid, 32'd1);
        chk("rw_bresp", m1_bresp, RESP_SLVERR);
        tick();
        s_bvalid = 1'b0; s_bresp = RESP_OKAY; m1_bready = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0;

        // LSU holds rready low for four cycles while data is offered
        tick();
        m1_araddr = A1; m1_arvalid = 1'b1; s_arready = 1'b1;
        tick(); tick();
        m1_arvalid = 1'b0; s_arready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'h7777_1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("stall_s_rready", s_rready, 32'd0);
            chk("stall_rvalid", m1_rvalid, 32'd1);
            chk("stall_rdata", m1_rdata, 32'h7777_1111);
            tick();
        end
        m1_rready = 1'b1;
        #1;
        chk("stall_release", s_rready, 32'd1);
        tick();
        s_rvalid = 1'b0; s_rdata = 32'h0; m1_rready = 1'b0;
        #1;
        chk("stall_done", {m1_rvalid, s_rready}, 32'd0);

        // Asynchronous reset while waiting in the write-response state
        m1_awaddr = AW; m1_awvalid = 1'b1; m1_wvalid = 1'b1; m1_wdata = 32'h1;
        m1_wstrb = WSTRB_BYTE; s_awready = 1'b1; s_wready = 1'b1;
        tick(); tick();
        m1_awvalid = 1'b0; m1_wvalid = 1'b0;
        s_bvalid = 1'b1; m1_bready = 1'b1;
        #1;
        chk("rstb_pre_bvalid", m1_bvalid, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstb_ctl", all_ctl(), 32'd0);
        chk("rstb_data", all_data_or(), 32'd0);
        clear_inputs();
        #1;
        rst = 1'b1;
        tick();
        chk("rstb_after", all_ctl(), 32'd0);
        m0_araddr = A0; m0_arvalid = 1'b1;
        slave_read(0, A0, 32'h0000_0093, RESP_OKAY, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
